// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and parameter helpers for the lap stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } sw_state_e;

    localparam logic [3:0] DIGIT_MAX_DEC = 4'd9;  // decimal digit
    localparam logic [3:0] DIGIT_MAX_SEX = 4'd5;  // tens of seconds / minutes

    // Number of BCD digits in the time chain.
    function automatic int calc_nd(input int has_hours);
        return (has_hours != 0) ? 8 : 6;
    endfunction

    // Clock cycles per count tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Digit order from LSB: ff units, ff tens, ss units, ss tens, mm units, mm tens, hh, hh.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 3 || idx == 5) ? DIGIT_MAX_SEX : DIGIT_MAX_DEC;
    endfunction

endpackage

// File: rtl/lap_stopwatch_core_if.sv
// Command / display bundle between the button side and the stopwatch core.
interface lap_stopwatch_core_if #(
    parameter int HAS_HOURS = 0,
    parameter int LAP_DEPTH = 4
);
    import stopwatch_pkg::*;

    localparam int ND = calc_nd(HAS_HOURS);
    localparam int CW = $clog2(LAP_DEPTH) + 1;

    logic            start_stop;
    logic            lap;
    logic            clear;
    logic            down_mode;
    logic [4*ND-1:0] preset_bcd;
    logic            lap_rd;
    logic [4*ND-1:0] time_bcd;
    logic [4*ND-1:0] lap_bcd;
    logic [CW-1:0]   lap_count;
    logic            lap_overflow;
    logic            running;
    logic            expired;
    logic            wrapped;

    modport master (
        output start_stop, lap, clear, down_mode, preset_bcd, lap_rd,
        input  time_bcd, lap_bcd, lap_count, lap_overflow, running, expired, wrapped
    );

    modport slave (
        input  start_stop, lap, clear, down_mode, preset_bcd, lap_rd,
        output time_bcd, lap_bcd, lap_count, lap_overflow, running, expired, wrapped
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit with up/down count, clamped parallel load and ripple carry/borrow.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,       // 0 = up, 1 = down
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       carry,
    output logic       borrow
);
    logic [3:0] q_q, q_d;

    // Next digit value: load wins over counting, out-of-range loads clamp to MAX.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            if (dir) q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
            else     q_d = (q_q >= MAX)  ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q      = q_q;
    assign carry  = en & ~dir & (q_q == MAX);
    assign borrow = en &  dir & (q_q == 4'd0);

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch / countdown core: tick divider, BCD time chain, run FSM and lap FIFO.
module lap_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HAS_HOURS = 0,
    parameter int LAP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    lap_stopwatch_core_if.slave   bus
);
    localparam int ND  = calc_nd(HAS_HOURS);
    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int TW  = 4 * ND;
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int CW  = AW + 1;
    localparam int DW  = $clog2(DIV);

    sw_state_e      state_q, state_d;
    logic           running_q, expired_q;
    logic           mode_q, mode_d;
    logic [DW-1:0]  div_q, div_d;
    logic           wrapped_q, wrapped_d;

    logic [TW-1:0]  time_cur;
    logic [ND-1:0]  dig_en, dig_carry, dig_borrow, dig_out;
    logic           tick, load, chain_en, expire_hit;
    logic [TW-1:0]  load_val;

    // Tick on the last divider count; the divider only advances while in RUN.
    assign tick = (state_q == ST_RUN) && (div_q == DW'(DIV - 1));

    // Entering IDLE (clear, or leaving EXPIRED) reloads zero or the preset.
    assign load     = bus.clear || (state_q == ST_EXPIRED && bus.start_stop);
    assign load_val = bus.down_mode ? bus.preset_bcd : '0;

    // A countdown already at zero must not borrow into 59:59.99.
    assign chain_en   = tick && !(mode_q && time_cur == '0) && !load;
    assign expire_hit = tick && mode_q && (time_cur == '0 || time_cur == TW'(1));

    assign dig_out = dig_carry | dig_borrow;
    assign dig_en  = {dig_out[ND-2:0], chain_en};

    for (genvar i = 0; i < ND; i++) begin : g_dig
        bcd_digit #(.MAX(digit_max(i))) u_dig (
            .clk      (clk),
            .reset    (reset),
            .en       (dig_en[i]),
            .dir      (mode_q),
            .load     (load),
            .load_val (load_val[4*i +: 4]),
            .q        (time_cur[4*i +: 4]),
            .carry    (dig_carry[i]),
            .borrow   (dig_borrow[i])
        );
    end

    // Next state, direction latch, divider and wrap flag.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if (bus.start_stop) state_d = ST_RUN;
                ST_RUN:     if (expire_hit)     state_d = ST_EXPIRED;
                            else if (bus.start_stop) state_d = ST_PAUSED;
                ST_PAUSED:  if (bus.start_stop) state_d = ST_RUN;
                ST_EXPIRED: if (bus.start_stop) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
        mode_d = (state_q == ST_IDLE) ? bus.down_mode : mode_q;
        div_d  = '0;
        if (state_q == ST_RUN && state_d == ST_RUN)
            div_d = (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
        wrapped_d = wrapped_q;
        if (bus.clear)                         wrapped_d = 1'b0;
        else if (dig_out[ND-1] && !mode_q)     wrapped_d = 1'b1;
    end

    // FSM state with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            mode_q    <= 1'b0;
            div_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
            mode_q    <= mode_d;
            div_q     <= div_d;
            wrapped_q <= wrapped_d;
        end
    end

    // ---------------- lap FIFO ----------------
    logic [TW-1:0] mem_q [LAP_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [TW-1:0] lap_bcd_q, lap_bcd_d;
    logic          full, push, pop;

    assign full = (cnt_q == CW'(LAP_DEPTH));
    assign push = bus.lap && (state_q == ST_RUN || state_q == ST_PAUSED) && !bus.clear;
    assign pop  = bus.lap_rd && (cnt_q != '0) && !bus.clear;

    // Pointer/count update; a push into a full FIFO drops the oldest entry.
    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        lap_bcd_d = lap_bcd_q;
        if (bus.clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (pop)                  lap_bcd_d = mem_q[rd_q];
            if (push)                 wr_d = wr_q + AW'(1);
            if (pop || (push && full)) rd_d = rd_q + AW'(1);
            if (push && full && !pop) ovf_d = 1'b1;
            if (push && !pop && !full)  cnt_d = cnt_q + CW'(1);
            else if (pop && !push)      cnt_d = cnt_q - CW'(1);
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            lap_bcd_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            lap_bcd_q <= lap_bcd_d;
        end
    end

    // Lap storage captures the registered (pre-tick) time.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= time_cur;
    end

    assign bus.time_bcd     = time_cur;
    assign bus.lap_bcd      = lap_bcd_q;
    assign bus.lap_count    = cnt_q;
    assign bus.lap_overflow = ovf_q;
    assign bus.running      = running_q;
    assign bus.expired      = expired_q;
    assign bus.wrapped      = wrapped_q;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Randomized + directed bench for lap_stopwatch_core against a centisecond-level model.
module tb_lap_stopwatch_core;
    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int HAS_HOURS = 0;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int ND        = (HAS_HOURS != 0) ? 8 : 6;
    localparam int TW        = 4 * ND;
    localparam int MAX_CS    = (HAS_HOURS != 0) ? 35999999 : 359999;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lap_stopwatch_core_if #(.HAS_HOURS(HAS_HOURS), .LAP_DEPTH(LAP_DEPTH)) sw_if ();

    lap_stopwatch_core #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HAS_HOURS(HAS_HOURS), .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw_if.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: time held as a plain centisecond count.
    int            m_state = M_IDLE;
    int            m_div   = 0;
    int            m_t     = 0;
    bit            m_mode  = 0;
    bit            m_wrap  = 0;
    bit            m_ovf   = 0;
    logic [TW-1:0] m_lap   = '0;
    logic [TW-1:0] m_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] cs_to_bcd(input int cs);
        int c, s, m, h;
        logic [31:0] r;
        c = cs % 100;
        s = (cs / 100) % 60;
        m = (cs / 6000) % 60;
        h = cs / 360000;
        r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
             4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
        return r[TW-1:0];
    endfunction

    function automatic int preset_to_cs(input logic [TW-1:0] p);
        int d[8];
        int lim;
        logic [31:0] w;
        w = 32'(p);
        for (int i = 0; i < 8; i++) begin
            d[i] = int'(w[4*i +: 4]);
            lim  = (i == 3 || i == 5) ? 5 : 9;
            if (d[i] > lim) d[i] = lim;
        end
        return ((((d[7]*10 + d[6])*60 + d[5]*10 + d[4])*60 + d[3]*10 + d[2])*100 + d[1]*10 + d[0]);
    endfunction

    // Advance the model by one clock using the inputs sampled at this edge.
    task automatic model_step();
        bit tick, push, pop, expire;
        int ns;
        logic [TW-1:0] cur;
        if (reset) begin
            m_state = M_IDLE; m_div = 0; m_t = 0; m_mode = 0;
            m_wrap = 0; m_ovf = 0; m_lap = '0; m_q.delete();
        end else begin
            tick = (m_state == M_RUN) && (m_div == DIV - 1);
            push = sw_if.lap && (m_state == M_RUN || m_state == M_PAUSED);
            pop  = sw_if.lap_rd && (m_q.size() > 0);
            cur  = cs_to_bcd(m_t);
            ns   = m_state;
            if (m_state == M_IDLE) m_mode = sw_if.down_mode;
            else if (sw_if.clear) m_mode = m_mode;
            if (sw_if.clear) begin
                ns     = M_IDLE;
                m_t    = sw_if.down_mode ? preset_to_cs(sw_if.preset_bcd) : 0;
                m_wrap = 0;
                m_ovf  = 0;
                m_q.delete();
            end else begin
                if (pop) m_lap = m_q.pop_front();
                if (push) begin
                    if (m_q.size() == LAP_DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1;
                    end
                    m_q.push_back(cur);
                end
                expire = 0;
                if (tick) begin
                    // direction is whatever was latched while IDLE, before this edge
                    if (m_state == M_RUN && dut_dir_down()) begin
                        if (m_t <= 1) expire = 1;
                        if (m_t > 0) m_t--;
                    end else if (m_t == MAX_CS) begin
                        m_t = 0;
                        m_wrap = 1;
                    end else begin
                        m_t++;
                    end
                end
                case (m_state)
                    M_IDLE:    if (sw_if.start_stop) ns = M_RUN;
                    M_RUN:     if (expire) ns = M_EXPIRED;
                               else if (sw_if.start_stop) ns = M_PAUSED;
                    M_PAUSED:  if (sw_if.start_stop) ns = M_RUN;
                    M_EXPIRED: if (sw_if.start_stop) begin
                                   ns  = M_IDLE;
                                   m_t = sw_if.down_mode ? preset_to_cs(sw_if.preset_bcd) : 0;
                               end
                    default:   ns = M_IDLE;
                endcase
            end
            m_div   = (m_state == M_RUN && ns == M_RUN) ? (m_div + 1) % DIV : 0;
            m_state = ns;
        end
    endtask

    // Direction used for the run in progress (latched by the model when it left IDLE).
    bit m_run_down = 0;
    function automatic bit dut_dir_down();
        return m_run_down;
    endfunction

    task automatic compare_all();
        check_eq("time_bcd",     32'(sw_if.time_bcd),     32'(cs_to_bcd(m_t)));
        check_eq("lap_bcd",      32'(sw_if.lap_bcd),      32'(m_lap));
        check_eq("lap_count",    32'(sw_if.lap_count),    32'(m_q.size()));
        check_eq("lap_overflow", 32'(sw_if.lap_overflow), 32'(m_ovf));
        check_eq("running",      32'(sw_if.running),      32'(m_state == M_RUN));
        check_eq("expired",      32'(sw_if.expired),      32'(m_state == M_EXPIRED));
        check_eq("wrapped",      32'(sw_if.wrapped),      32'(m_wrap));
    endtask

    // One clock: model follows the edge, outputs checked mid-cycle, pulses dropped.
    task automatic step();
        @(posedge clk);
        m_run_down = m_mode;
        model_step();
        @(negedge clk);
        compare_all();
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap_rd     = 1'b0;
        reset            = 1'b0;
    endtask

    initial begin
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap_rd     = 1'b0;
        sw_if.down_mode  = 1'b0;
        sw_if.preset_bcd = '0;
        reset            = 1'b1;
        step();
        reset = 1'b1;
        step();
        check_eq("rst_time",  32'(sw_if.time_bcd),  32'h0);
        check_eq("rst_count", 32'(sw_if.lap_count), 32'h0);

        // Run 150 cycles, then pause 50.
        sw_if.start_stop = 1'b1; step();
        repeat (150) step();
        check_eq("run150_time", 32'(sw_if.time_bcd), 32'h000015);
        check_eq("run150_running", 32'(sw_if.running), 32'h1);
        sw_if.start_stop = 1'b1; step();
        repeat (50) step();
        check_eq("pause_hold", 32'(sw_if.time_bcd), 32'h000015);

        // Resume and take five laps into a four-deep FIFO.
        sw_if.start_stop = 1'b1; step();
        for (int k = 0; k < 5; k++) begin
            repeat (7) step();
            sw_if.lap = 1'b1; step();
        end
        check_eq("laps_count", 32'(sw_if.lap_count), 32'd4);
        check_eq("laps_ovf",   32'(sw_if.lap_overflow), 32'h1);
        sw_if.lap_rd = 1'b1; step();
        check_eq("lap_pop_second", 32'(sw_if.lap_bcd), 32'h000016);

        // Reset mid-run with a non-empty FIFO.
        repeat (3) step();
        reset = 1'b1; step();
        check_eq("midrst_time",  32'(sw_if.time_bcd),  32'h0);
        check_eq("midrst_count", 32'(sw_if.lap_count), 32'h0);
        check_eq("midrst_lap",   32'(sw_if.lap_bcd),   32'h0);
        check_eq("midrst_run",   32'(sw_if.running),   32'h0);

        // Lap on the same edge as a tick captures the pre-tick value.
        sw_if.start_stop = 1'b1; step();
        repeat (79) step();
        check_eq("pre_tick", 32'(sw_if.time_bcd), 32'h000007);
        sw_if.lap = 1'b1; step();
        check_eq("post_tick", 32'(sw_if.time_bcd), 32'h000008);
        sw_if.lap_rd = 1'b1; step();
        check_eq("tick_lap", 32'(sw_if.lap_bcd), 32'h000007);
        sw_if.clear = 1'b1; step();

        // Count-up wrap from 59:59.98 (preset loaded, then up mode latched in IDLE).
        sw_if.down_mode = 1'b1; sw_if.preset_bcd = TW'(32'h595998);
        sw_if.clear = 1'b1; step();
        check_eq("wrap_load", 32'(sw_if.time_bcd), 32'h595998);
        sw_if.down_mode = 1'b0; step();
        sw_if.start_stop = 1'b1; step();
        repeat (20) step();
        check_eq("wrap_time", 32'(sw_if.time_bcd), 32'h0);
        check_eq("wrap_flag", 32'(sw_if.wrapped),  32'h1);
        sw_if.clear = 1'b1; step();
        check_eq("wrap_clear", 32'(sw_if.wrapped), 32'h0);

        // Countdown from 00:00.03 expires exactly 30 cycles after start.
        sw_if.down_mode = 1'b1; sw_if.preset_bcd = TW'(32'h000003);
        sw_if.clear = 1'b1; step();
        sw_if.start_stop = 1'b1; step();
        repeat (29) step();
        check_eq("cd_29_exp",  32'(sw_if.expired),  32'h0);
        check_eq("cd_29_time", 32'(sw_if.time_bcd), 32'h000001);
        step();
        check_eq("cd_30_exp",  32'(sw_if.expired),  32'h1);
        check_eq("cd_30_time", 32'(sw_if.time_bcd), 32'h0);
        sw_if.start_stop = 1'b1; step();
        check_eq("cd_reload", 32'(sw_if.time_bcd), 32'h000003);
        check_eq("cd_idle",   32'(sw_if.expired),  32'h0);

        // Invalid preset digits clamp to their per-digit maximum.
        sw_if.preset_bcd = TW'(32'hF7A9FC);
        sw_if.clear = 1'b1; step();
        check_eq("clamp", 32'(sw_if.time_bcd), 32'h575999);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            sw_if.start_stop = ($urandom_range(0, 29) == 0);
            sw_if.lap        = ($urandom_range(0, 5) == 0);
            sw_if.lap_rd     = ($urandom_range(0, 5) == 0);
            sw_if.clear      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) sw_if.down_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                sw_if.preset_bcd = ($urandom_range(0, 1) == 1) ? TW'($urandom) : TW'($urandom_range(0, 40));
            reset = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
